// File: rtl/vote_pkg.sv
// vote_pkg: shared FSM state type and majority threshold for the voter family
package vote_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;
    function automatic int maj_thresh(input int n);
        return n / 2;
    endfunction
endpackage

// File: rtl/vote_popcount.sv
// vote_popcount: combinational population count of an N-bit vector
//   in_bits  in   N                 bits to count
//   count    out  $clog2(N+1)       number of ones in in_bits
module vote_popcount #(
    parameter int N = 3
) (
    input  logic [N-1:0]           in_bits,
    output logic [$clog2(N+1)-1:0] count
);
    localparam int CW = $clog2(N + 1);
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) count = count + CW'(in_bits[i]);
    end
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: one-ballot-per-voter session with timeout and valid/ready majority result
//   clk, rst_n   clock and synchronous active-low reset
//   start        opens a session (IDLE only)
//   vote_en/val  per-voter ballot strobe and value (1 = yes)
//   busy         session open or result pending
//   voted        per-voter ballot-latched flags
//   res_valid/res_ready  result handshake
//   res_pass     yes count above half of N_VOTERS
//   res_timeout  session closed by timeout with ballots missing
//   res_tally    yes count, present only when VOTE_TALLY_EN is defined
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int N_VOTERS    = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_VOTERS-1:0]           vote_en,
    input  logic [N_VOTERS-1:0]           vote_val,
    output logic                          busy,
    output logic [N_VOTERS-1:0]           voted,
    output logic                          res_valid,
    input  logic                          res_ready,
`ifdef VOTE_TALLY_EN
    output logic [$clog2(N_VOTERS+1)-1:0] res_tally,
`endif
    output logic                          res_pass,
    output logic                          res_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam int TW    = $clog2(N_VOTERS + 1);
    localparam logic [TW-1:0]    THRESH = TW'(maj_thresh(N_VOTERS));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d, ballot_q, ballot_d, accept;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pass_q, pass_d, timeout_q, timeout_d, all_voted;
    logic [TW-1:0]       yes_cnt;
`ifdef VOTE_TALLY_EN
    logic [TW-1:0]       tally_q, tally_d;
`endif

    // counts the ballots as they will stand after this edge, so the closing vote is included
    vote_popcount #(.N(N_VOTERS)) u_pop (.in_bits(ballot_d & voted_d), .count(yes_cnt));

    assign accept    = (state_q == COLLECT) ? (vote_en & ~voted_q) : '0;
    assign all_voted = &(voted_q | accept);

    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        ballot_d  = ballot_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
`ifdef VOTE_TALLY_EN
        tally_d   = tally_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COLLECT;
                    cnt_d    = '0;
                    voted_d  = '0;
                    ballot_d = '0;
                end
            end
            COLLECT: begin
                voted_d  = voted_q | accept;
                ballot_d = (ballot_q & ~accept) | (vote_val & accept);
                cnt_d    = cnt_q + CNT_W'(1);
                // a ballot completing the set on the timeout edge closes as all-voted
                if (all_voted || cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    pass_d    = yes_cnt > THRESH;
                    timeout_d = !all_voted;
`ifdef VOTE_TALLY_EN
                    tally_d   = yes_cnt;
`endif
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    voted_d   = '0;
                    ballot_d  = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
`ifdef VOTE_TALLY_EN
                    tally_d   = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            voted_q   <= '0;
            ballot_q  <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef VOTE_TALLY_EN
            tally_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            voted_q   <= voted_d;
            ballot_q  <= ballot_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
`ifdef VOTE_TALLY_EN
            tally_q   <= tally_d;
`endif
        end
    end

    assign busy        = state_q != IDLE;
    assign voted       = voted_q;
    assign res_valid   = state_q == DONE;
    assign res_pass    = pass_q;
    assign res_timeout = timeout_q;
`ifdef VOTE_TALLY_EN
    assign res_tally   = tally_q;
`endif
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: scoreboard bench for vote_session_ctrl with a short timeout
module tb_vote_session_ctrl;
    localparam int N  = 3;
    localparam int TO = 8;
    localparam int TW = $clog2(N + 1);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, res_ready = 1'b0;
    logic [N-1:0]  vote_en = '0, vote_val = '0;
    logic          busy, res_valid, res_pass, res_timeout;
    logic [N-1:0]  voted;
`ifdef VOTE_TALLY_EN
    logic [TW-1:0] res_tally;
`endif

    typedef struct {
        logic          pass;
        logic          tmo;
        logic [TW-1:0] tally;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0, errors = 0;
    logic [N-1:0] m_voted = '0, m_ballot = '0;

    vote_session_ctrl #(.N_VOTERS(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_en(vote_en), .vote_val(vote_val),
        .busy(busy), .voted(voted), .res_valid(res_valid), .res_ready(res_ready),
`ifdef VOTE_TALLY_EN
        .res_tally(res_tally),
`endif
        .res_pass(res_pass), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        start = 1'b1;
        step();
        start = 1'b0;
        m_voted = '0;
        m_ballot = '0;
        chk("busy_open", 32'(busy), 1);
    endtask

    task automatic vote(input logic [N-1:0] en, input logic [N-1:0] val);
        vote_en = en;
        vote_val = val;
        for (int i = 0; i < N; i++)
            if (en[i] && !m_voted[i]) begin
                m_voted[i] = 1'b1;
                m_ballot[i] = val[i];
            end
        step();
        vote_en = '0;
        vote_val = '0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.tally = TW'($countones(m_ballot & m_voted));
        e.pass  = e.tally > TW'(N / 2);
        e.tmo   = ~&m_voted;
        sb.push_back(e);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        chk("res_valid_seen", 32'(res_valid), 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            for (int h = 0; h <= hold; h++) begin
                chk("res_pass", 32'(res_pass), 32'(e.pass));
                chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
`ifdef VOTE_TALLY_EN
                chk("res_tally", 32'(res_tally), 32'(e.tally));
`endif
                chk("voted_held", 32'(voted), 32'(m_voted));
                chk("valid_held", 32'(res_valid), 1);
                if (h < hold) step();
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("valid_clr", 32'(res_valid), 0);
        chk("busy_clr", 32'(busy), 0);
        chk("voted_clr", 32'(voted), 0);
        chk("pass_clr", 32'(res_pass), 0);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_voted", 32'(voted), 0);
        chk("rst_pass", 32'(res_pass), 0);
        chk("rst_timeout", 32'(res_timeout), 0);
        rst_n = 1'b1;
        step();
        vote(3'b111, 3'b111);
        chk("idle_ignores_votes", 32'(voted), 0);
        // reset mid-session discards ballots
        open_session();
        vote(3'b001, 3'b001);
        chk("pre_rst_voted", 32'(voted), 1);
        rst_n = 1'b0;
        repeat (2) step();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_voted", 32'(voted), 0);
        chk("midrst_valid", 32'(res_valid), 0);
        rst_n = 1'b1;
        // votes 1,1,0 on separate cycles
        open_session();
        chk("fresh_voted", 32'(voted), 0);
        vote(3'b001, 3'b001);
        chk("partial_voted", 32'(voted), 3'b001);
        vote(3'b010, 3'b010);
        chk("no_early_valid", 32'(res_valid), 0);
        vote(3'b100, 3'b000);
        push_exp();
        chk("latency_a", 32'(res_valid), 1);
        collect(0);
        // all three in one cycle, held for 5 cycles with start asserted
        open_session();
        vote(3'b111, 3'b100);
        push_exp();
        chk("latency_b", 32'(res_valid), 1);
        start = 1'b1;
        collect(5);
        start = 1'b0;
        step();
        chk("start_ignored", 32'(busy), 0);
        // re-vote ignored
        open_session();
        vote(3'b001, 3'b001);
        vote(3'b111, 3'b100);
        push_exp();
        chk("latency_c", 32'(res_valid), 1);
        collect(0);
        // timeout with only voter1
        open_session();
        vote(3'b010, 3'b010);
        repeat (6) step();
        chk("no_early_timeout", 32'(res_valid), 0);
        push_exp();
        step();
        chk("timeout_edge", 32'(res_valid), 1);
        collect(0);
        // last ballot on the timeout edge
        open_session();
        vote(3'b011, 3'b011);
        repeat (6) step();
        chk("no_early_e", 32'(res_valid), 0);
        vote(3'b100, 3'b000);
        push_exp();
        chk("ballot_wins", 32'(res_valid), 1);
        collect(0);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
